// File: rtl/mux8_pkg.sv
// rtl/mux8_pkg.sv - shared way-count, select-width and way-index constants for the 8-way mux/demux pair
// Purpose: constants shared by the gather-side merge and the scatter-side demux,
//          plus a rotate helper used by the round-robin arbiter.
// Ports:   none (package)
package mux8_pkg;

   localparam int MUX_WAYS  = 8;
   localparam int MUX_SEL_W = 3;

   localparam logic [MUX_SEL_W-1:0] WAY_A = 3'd0;
   localparam logic [MUX_SEL_W-1:0] WAY_B = 3'd1;
   localparam logic [MUX_SEL_W-1:0] WAY_C = 3'd2;
   localparam logic [MUX_SEL_W-1:0] WAY_D = 3'd3;
   localparam logic [MUX_SEL_W-1:0] WAY_E = 3'd4;
   localparam logic [MUX_SEL_W-1:0] WAY_F = 3'd5;
   localparam logic [MUX_SEL_W-1:0] WAY_G = 3'd6;
   localparam logic [MUX_SEL_W-1:0] WAY_H = 3'd7;

   // Rotate right so that bit n of v lands at bit 0.
   function automatic logic [MUX_WAYS-1:0] rotr8(input logic [MUX_WAYS-1:0] v,
                                                 input logic [MUX_SEL_W-1:0] n);
      logic [2*MUX_WAYS-1:0] dbl;
      dbl = {v, v} >> n;
      return dbl[MUX_WAYS-1:0];
   endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - combinational 8-way round-robin / fixed-priority arbiter
// Purpose: picks the first requesting way scanning from ptr (rr_en=1) or from 0 (rr_en=0).
// Ports:   req        in  8  request per way
//          ptr        in  3  scan start when rr_en=1
//          rr_en      in  1  1 = round-robin, 0 = lowest index wins
//          gnt_valid  out 1  some way requested
//          gnt_idx    out 3  granted way index
//          gnt_onehot out 8  one-hot granted way (zero when no request)
module rr_arbiter8
   import mux8_pkg::*;
(
   input  logic [MUX_WAYS-1:0]  req,
   input  logic [MUX_SEL_W-1:0] ptr,
   input  logic                 rr_en,
   output logic                 gnt_valid,
   output logic [MUX_SEL_W-1:0] gnt_idx,
   output logic [MUX_WAYS-1:0]  gnt_onehot
);

   logic [MUX_SEL_W-1:0] base;
   logic [MUX_WAYS-1:0]  rot;
   logic [MUX_SEL_W-1:0] rot_idx;

   // Rotate the request vector so the scan start sits at bit 0, take the
   // lowest set bit, then add the start back to recover the real way index.
   always_comb begin
      base    = rr_en ? ptr : WAY_A;
      rot     = rotr8(req, base);
      rot_idx = '0;
      for (int j = MUX_WAYS - 1; j >= 0; j--) begin
         if (rot[j]) rot_idx = MUX_SEL_W'(j);
      end
      gnt_valid  = |req;
      gnt_idx    = rot_idx + base;
      gnt_onehot = gnt_valid ? (MUX_WAYS'(1) << gnt_idx) : '0;
   end

endmodule

// File: rtl/mux8way_rr_merge.sv
// rtl/mux8way_rr_merge.sv - 8-to-1 valid/ready stream merge with registered word and source index
// Purpose: arbitrates 8 input streams onto one registered output, tagging each word with its way.
// Ports:   clk        in  1        clock
//          reset      in  1        synchronous active-high reset
//          in_valid   in  8        per-way request
//          in_data    in  8*WIDTH  way i word at [i*WIDTH +: WIDTH]
//          in_ready   out 8        one-hot accept strobe
//          out_valid  out 1        output register holds a word
//          out_data   out WIDTH    registered word
//          out_sel    out 3        registered source way
//          out_ready  in  1        downstream accept
module mux8way_rr_merge
   import mux8_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter bit RR_EN = 1'b1
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [MUX_WAYS-1:0]       in_valid,
   input  logic [MUX_WAYS*WIDTH-1:0] in_data,
   output logic [MUX_WAYS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [MUX_SEL_W-1:0]      out_sel,
   input  logic                      out_ready
);

   logic [MUX_SEL_W-1:0] ptr;
   logic                 gnt_valid;
   logic [MUX_SEL_W-1:0] gnt_idx;
   logic [MUX_WAYS-1:0]  gnt_onehot;
   logic                 load;
   logic                 take;
   logic [WIDTH-1:0]     gnt_word;

   rr_arbiter8 u_arb (
      .req        (in_valid),
      .ptr        (ptr),
      .rr_en      (RR_EN),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot)
   );

   // Output stage can take a word when empty or when its current word drains this cycle.
   assign load     = ~out_valid | out_ready;
   assign in_ready = (load & gnt_valid & ~reset) ? gnt_onehot : '0;
   assign take     = |(in_valid & in_ready);
   assign gnt_word = in_data[gnt_idx*WIDTH +: WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_data  <= gnt_word;
         out_sel   <= gnt_idx;
         ptr       <= gnt_idx + MUX_SEL_W'(1);
      end else if (out_ready) begin
         // Drain with nothing to refill; data and sel keep their last values.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux8way_rr_merge.sv
// tb/tb_mux8way_rr_merge.sv - directed self-checking bench for mux8way_rr_merge
module tb_mux8way_rr_merge;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   in_valid;
   logic [127:0] in_data;
   logic         out_ready;

   logic [7:0]   in_ready;
   logic         out_valid;
   logic [15:0]  out_data;
   logic [2:0]   out_sel;

   logic [7:0]   fp_in_ready;
   logic         fp_out_valid;
   logic [15:0]  fp_out_data;
   logic [2:0]   fp_out_sel;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mux8way_rr_merge #(.WIDTH(16), .RR_EN(1'b1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   mux8way_rr_merge #(.WIDTH(16), .RR_EN(1'b0)) dut_fp (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (fp_in_ready),
      .out_valid (fp_out_valid),
      .out_data  (fp_out_data),
      .out_sel   (fp_out_sel),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] g;

      // Reset state
      reset     = 1'b1;
      in_valid  = 8'h00;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_sel",   32'(out_sel),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);

      // 1. Idle after reset
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("idle_out_valid", 32'(out_valid), 32'd0);
         chk("idle_in_ready",  32'(in_ready),  32'd0);
         chk("idle_out_sel",   32'(out_sel),   32'd0);
      end

      // 2. Single way 5
      in_data[5*16 +: 16] = 16'hBEEF;
      in_valid  = 8'h20;
      out_ready = 1'b1;
      #1;
      chk("single_in_ready", 32'(in_ready), 32'h20);
      tick();
      chk("single_out_valid", 32'(out_valid), 32'd1);
      chk("single_out_data",  32'(out_data),  32'hBEEF);
      chk("single_out_sel",   32'(out_sel),   32'd5);

      // 3. Round-robin wrap from ptr=6 with all ways valid
      for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'hA000 + 16'(i);
      in_valid = 8'hFF;
      #1;
      for (int k = 0; k < 9; k++) begin
         g = 3'(6 + k);
         chk("rr_in_ready", 32'(in_ready), 32'(8'd1 << g));
         tick();
         chk("rr_out_valid", 32'(out_valid), 32'd1);
         chk("rr_out_sel",   32'(out_sel),   32'(g));
         chk("rr_out_data",  32'(out_data),  32'h0000A000 + 32'(g));
      end

      // 4. Backpressure: hold word from way 6, then drain+refill together
      out_ready = 1'b0;
      in_valid  = 8'h03;
      #1;
      for (int c = 0; c < 4; c++) begin
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_sel",   32'(out_sel),   32'd6);
         chk("bp_out_data",  32'(out_data),  32'hA006);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 32'(in_ready), 32'h01);
      tick();
      chk("bp_refill_valid", 32'(out_valid), 32'd1);
      chk("bp_refill_sel",   32'(out_sel),   32'd0);
      chk("bp_refill_data",  32'(out_data),  32'hA000);
      in_valid = 8'h00;
      tick();
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_out_sel",   32'(out_sel),   32'd0);
      chk("drain_out_data",  32'(out_data),  32'hA000);

      // 5. Fixed priority vs round-robin with ways 2 and 7 valid (rr ptr=1)
      in_valid = 8'h84;
      #1;
      for (int c = 0; c < 4; c++) begin
         g = c[0] ? 3'd7 : 3'd2;
         chk("fp_in_ready", 32'(fp_in_ready), 32'h04);
         chk("rr_alt_in_ready", 32'(in_ready), 32'(8'd1 << g));
         tick();
         chk("fp_out_sel",  32'(fp_out_sel),  32'd2);
         chk("fp_out_data", 32'(fp_out_data), 32'hA002);
         chk("rr_alt_out_sel", 32'(out_sel), 32'(g));
      end

      // 6. Reset mid-stream
      in_valid = 8'hFF;
      #1;
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_in_ready",    32'(in_ready),    32'd0);
      chk("rst_mid_fp_in_ready", 32'(fp_in_ready), 32'd0);
      tick();
      chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_in_ready2", 32'(in_ready),  32'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'h01);
      tick();
      chk("post_rst_out_valid", 32'(out_valid), 32'd1);
      chk("post_rst_out_sel",   32'(out_sel),   32'd0);
      chk("post_rst_out_data",  32'(out_data),  32'hA000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
